// File: rtl/frame_capture_pkg.sv
// Shared types and register map for the frame capture controller.
package frame_capture_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    CAPTURE = 2'd2,
    DRAIN   = 2'd3
  } state_t;

  localparam logic [1:0] REG_CONTROL     = 2'd0;
  localparam logic [1:0] REG_STATUS      = 2'd1;
  localparam logic [1:0] REG_PIXEL_COUNT = 2'd2;
  localparam logic [1:0] REG_FRAME_COUNT = 2'd3;

  localparam int CTRL_ARM    = 0;
  localparam int CTRL_CONT   = 1;
  localparam int CTRL_IRQ_EN = 2;
  localparam int CTRL_ABORT  = 3;

  localparam int STAT_DONE  = 2;
  localparam int STAT_SHORT = 3;
  localparam int STAT_LONG  = 4;

endpackage

// File: rtl/frame_capture_regs.sv
// Avalon-MM register file: control bits, command pulses, sticky W1C status and counters.
module frame_capture_regs
  import frame_capture_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic [1:0]  mm_address,
  input  logic        mm_read,
  input  logic        mm_write,
  input  logic [31:0] mm_writedata,
  output logic [31:0] mm_readdata,
  input  state_t      state,
  input  logic        frame_done,
  input  logic        short_set,
  input  logic        long_set,
  input  logic [31:0] final_count,
  output logic        arm,
  output logic        abort,
  output logic        continuous,
  output logic        irq_en,
  output logic        frame_irq
);

  logic        ctrl_wr, stat_wr;
  logic        done, short_err, long_err;
  logic [31:0] pixel_count, frame_count;
  logic [31:0] rd_mux;
  logic        unused_wd;

  assign ctrl_wr   = mm_write && (mm_address == REG_CONTROL);
  assign stat_wr   = mm_write && (mm_address == REG_STATUS);
  assign abort     = ctrl_wr & mm_writedata[CTRL_ABORT];
  assign arm       = ctrl_wr & mm_writedata[CTRL_ARM] & ~mm_writedata[CTRL_ABORT];
  assign frame_irq = done & irq_en;
  assign unused_wd = ^mm_writedata[31:5];

  always_comb begin
    rd_mux = '0;
    case (mm_address)
      REG_CONTROL:     rd_mux = {28'b0, 1'b0, irq_en, continuous, 1'b0};
      REG_STATUS:      rd_mux = {27'b0, long_err, short_err, done, state};
      REG_PIXEL_COUNT: rd_mux = pixel_count;
      default:         rd_mux = frame_count;
    endcase
  end

  // Sticky status: a set arriving in the same cycle as its W1C clear wins.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      continuous  <= 1'b0;
      irq_en      <= 1'b0;
      done        <= 1'b0;
      short_err   <= 1'b0;
      long_err    <= 1'b0;
      pixel_count <= '0;
      frame_count <= '0;
      mm_readdata <= '0;
    end else begin
      if (ctrl_wr) begin
        continuous <= mm_writedata[CTRL_CONT];
        irq_en     <= mm_writedata[CTRL_IRQ_EN];
      end
      done      <= frame_done | (done      & ~(stat_wr & mm_writedata[STAT_DONE]));
      short_err <= short_set  | (short_err & ~(stat_wr & mm_writedata[STAT_SHORT]));
      long_err  <= long_set   | (long_err  & ~(stat_wr & mm_writedata[STAT_LONG]));
      if (frame_done) begin
        pixel_count <= final_count;
        frame_count <= frame_count + 32'd1;
      end
      if (mm_read) mm_readdata <= rd_mux;
    end
  end

endmodule

// File: rtl/frame_capture_ctrl.sv
// Captures SOP-aligned Avalon-ST video frames into the frame buffer and checks frame length.
module frame_capture_ctrl
  import frame_capture_pkg::*;
#(
  parameter int FRAME_PIXELS = 307200,
  parameter int ADDR_W       = 19
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [23:0]       sink_data,
  input  logic              sink_valid,
  output logic              sink_ready,
  input  logic              sink_startofpacket,
  input  logic              sink_endofpacket,
  input  logic [1:0]        mm_address,
  input  logic              mm_read,
  output logic [31:0]       mm_readdata,
  input  logic              mm_write,
  input  logic [31:0]       mm_writedata,
  output logic              buf_wr_en,
  output logic [ADDR_W-1:0] buf_wr_addr,
  output logic [31:0]       buf_wr_data,
  output logic              frame_irq
);

  // One extra bit so the final count can represent FRAME_PIXELS itself.
  localparam int               CNT_W     = ADDR_W + 1;
  localparam logic [CNT_W-1:0] FRAME_LEN = CNT_W'(FRAME_PIXELS);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt, beat_idx, beat_nxt, final_cnt;
  logic             take, wr_en, complete, short_set, long_set;
  logic             arm, abort, continuous, irq_en;

  assign sink_ready = 1'b1;
  assign beat_idx   = sink_startofpacket ? '0 : cnt;
  assign beat_nxt   = beat_idx + 1'b1;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    take      = 1'b0;
    wr_en     = 1'b0;
    complete  = 1'b0;
    short_set = 1'b0;
    long_set  = 1'b0;
    final_cnt = beat_nxt;
    case (state)
      IDLE:    if (arm) state_nxt = ARMED;
      ARMED:   take = sink_valid & sink_startofpacket;
      CAPTURE: begin
        take      = sink_valid;
        short_set = sink_valid & sink_startofpacket;
      end
      DRAIN: begin
        final_cnt = FRAME_LEN;
        complete  = sink_valid & sink_endofpacket;
      end
      default: state_nxt = IDLE;
    endcase
    // SOP always restarts at address 0, so ARMED and CAPTURE share the beat path.
    if (take) begin
      wr_en = 1'b1;
      if (sink_endofpacket) begin
        complete = 1'b1;
        if (beat_nxt < FRAME_LEN) short_set = 1'b1;
      end else if (beat_nxt == FRAME_LEN) begin
        long_set  = 1'b1;
        state_nxt = DRAIN;
      end else begin
        cnt_nxt   = beat_nxt;
        state_nxt = CAPTURE;
      end
    end
    if (complete) state_nxt = continuous ? ARMED : IDLE;
    if (abort) begin
      state_nxt = IDLE;
      wr_en     = 1'b0;
      complete  = 1'b0;
      short_set = 1'b0;
      long_set  = 1'b0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      buf_wr_en   <= 1'b0;
      buf_wr_addr <= '0;
      buf_wr_data <= '0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      buf_wr_en <= wr_en;
      if (wr_en) begin
        buf_wr_addr <= beat_idx[ADDR_W-1:0];
        buf_wr_data <= {8'b0, sink_data};
      end
    end
  end

  frame_capture_regs u_regs (
    .clock        (clock),
    .reset        (reset),
    .mm_address   (mm_address),
    .mm_read      (mm_read),
    .mm_write     (mm_write),
    .mm_writedata (mm_writedata),
    .mm_readdata  (mm_readdata),
    .state        (state),
    .frame_done   (complete),
    .short_set    (short_set),
    .long_set     (long_set),
    .final_count  (32'(final_cnt)),
    .arm          (arm),
    .abort        (abort),
    .continuous   (continuous),
    .irq_en       (irq_en),
    .frame_irq    (frame_irq)
  );

endmodule

// File: tb/tb_frame_capture_ctrl.sv
// Directed bench for frame_capture_ctrl with a write-scoreboard on the buffer port.
module tb_frame_capture_ctrl;
  import frame_capture_pkg::*;

  localparam int FP = 16;
  localparam int AW = 4;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic [23:0]   sink_data = '0;
  logic          sink_valid = 1'b0;
  logic          sink_ready;
  logic          sink_startofpacket = 1'b0;
  logic          sink_endofpacket = 1'b0;
  logic [1:0]    mm_address = '0;
  logic          mm_read = 1'b0;
  logic [31:0]   mm_readdata;
  logic          mm_write = 1'b0;
  logic [31:0]   mm_writedata = '0;
  logic          buf_wr_en;
  logic [AW-1:0] buf_wr_addr;
  logic [31:0]   buf_wr_data;
  logic          frame_irq;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [31:0]   data;
  } wr_t;

  wr_t exp_q[$];
  int  checks = 0;
  int  failures = 0;

  frame_capture_ctrl #(.FRAME_PIXELS(FP), .ADDR_W(AW)) dut (
    .clock              (clock),
    .reset              (reset),
    .sink_data          (sink_data),
    .sink_valid         (sink_valid),
    .sink_ready         (sink_ready),
    .sink_startofpacket (sink_startofpacket),
    .sink_endofpacket   (sink_endofpacket),
    .mm_address         (mm_address),
    .mm_read            (mm_read),
    .mm_readdata        (mm_readdata),
    .mm_write           (mm_write),
    .mm_writedata       (mm_writedata),
    .buf_wr_en          (buf_wr_en),
    .buf_wr_addr        (buf_wr_addr),
    .buf_wr_data        (buf_wr_data),
    .frame_irq          (frame_irq)
  );

  always #5 clock = ~clock;

  // Every buffer write must match the oldest expected write.
  always @(negedge clock) begin : mon
    wr_t e;
    if (buf_wr_en) begin
      checks++;
      assert (exp_q.size() != 0) else begin
        failures++;
        $error("FAIL buf_wr_extra: got addr=%0h data=%0h, required no write", buf_wr_addr, buf_wr_data);
      end
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        checks++;
        assert ({buf_wr_addr, buf_wr_data} === e) else begin
          failures++;
          $error("FAIL buf_wr: got addr=%0h data=%0h, required addr=%0h data=%0h",
                 buf_wr_addr, buf_wr_data, e.addr, e.data);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: got %0h, required %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    sink_valid = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic mm_wr(input logic [1:0] a, input logic [31:0] d);
    mm_address = a;
    mm_writedata = d;
    mm_write = 1'b1;
    tick();
    mm_write = 1'b0;
  endtask

  task automatic mm_rd_chk(input string tag, input logic [1:0] a, input logic [31:0] exp);
    mm_address = a;
    mm_read = 1'b1;
    tick();
    mm_read = 1'b0;
    chk(tag, mm_readdata, exp);
  endtask

  // One beat; sink_valid stays high so consecutive beats are back-to-back.
  task automatic beat(input logic [23:0] d, input logic sop, input logic eop,
                      input logic push, input int addr);
    sink_data = d;
    sink_startofpacket = sop;
    sink_endofpacket = eop;
    sink_valid = 1'b1;
    if (push) exp_q.push_back('{addr: AW'(addr), data: {8'b0, d}});
    tick();
  endtask

  task automatic gap(input int n);
    sink_valid = 1'b0;
    sink_startofpacket = 1'b0;
    sink_endofpacket = 1'b0;
    repeat (n) tick();
  endtask

  // n beats from SOP, EOP on beat eop_at, only the first push_lim beats land in the buffer.
  task automatic frame(input int base, input int n, input int eop_at, input int push_lim);
    for (int i = 0; i < n; i++)
      beat(24'(base + i), i == 0, i == eop_at, i < push_lim, i);
    gap(2);
  endtask

  initial begin
    repeat (2) tick();
    reset = 1'b0;
    tick();
    chk("rst_wr_en", {31'b0, buf_wr_en}, 32'd0);
    chk("rst_irq", {31'b0, frame_irq}, 32'd0);
    chk("rst_readdata", mm_readdata, 32'd0);
    chk("rst_ready", {31'b0, sink_ready}, 32'd1);
    mm_rd_chk("rst_status", REG_STATUS, 32'd0);
    mm_rd_chk("rst_frame_count", REG_FRAME_COUNT, 32'd0);

    // 1: single-shot, junk before SOP dropped
    mm_wr(REG_CONTROL, 32'h1);
    mm_rd_chk("t1_armed", REG_STATUS, 32'h1);
    for (int i = 0; i < 3; i++) beat(24'hAA0 + 24'(i), 1'b0, 1'b0, 1'b0, 0);
    frame(0, 16, 15, 16);
    mm_rd_chk("t1_status", REG_STATUS, 32'h4);
    mm_wr(REG_PIXEL_COUNT, 32'hFFFF);
    mm_rd_chk("t1_pixel_count", REG_PIXEL_COUNT, 32'd16);
    mm_rd_chk("t1_frame_count", REG_FRAME_COUNT, 32'd1);
    mm_rd_chk("t1_control", REG_CONTROL, 32'h0);
    chk("t1_q_empty", 32'(exp_q.size()), 32'd0);

    // 2: continuous with IRQ, three frames
    do_reset();
    mm_wr(REG_CONTROL, 32'h7);
    mm_rd_chk("t2_control", REG_CONTROL, 32'h6);
    chk("t2_irq_pre", {31'b0, frame_irq}, 32'd0);
    frame(32'h100, 16, 15, 16);
    chk("t2_irq_f1", {31'b0, frame_irq}, 32'd1);
    frame(32'h200, 16, 15, 16);
    frame(32'h300, 16, 15, 16);
    mm_rd_chk("t2_frame_count", REG_FRAME_COUNT, 32'd3);
    mm_rd_chk("t2_status", REG_STATUS, 32'h5);
    mm_wr(REG_STATUS, 32'h4);
    chk("t2_irq_cleared", {31'b0, frame_irq}, 32'd0);
    chk("t2_q_empty", 32'(exp_q.size()), 32'd0);

    // 3: short frame then long frame
    do_reset();
    mm_wr(REG_CONTROL, 32'h1);
    frame(32'h400, 10, 9, 10);
    mm_rd_chk("t3_short_status", REG_STATUS, 32'hC);
    mm_rd_chk("t3_short_count", REG_PIXEL_COUNT, 32'd10);
    mm_wr(REG_STATUS, 32'h1C);
    mm_rd_chk("t3_w1c", REG_STATUS, 32'h0);
    mm_wr(REG_CONTROL, 32'h1);
    frame(32'h500, 20, 19, 16);
    mm_rd_chk("t3_long_status", REG_STATUS, 32'h14);
    mm_rd_chk("t3_long_count", REG_PIXEL_COUNT, 32'd16);
    mm_rd_chk("t3_frame_count", REG_FRAME_COUNT, 32'd2);
    chk("t3_q_empty", 32'(exp_q.size()), 32'd0);

    // 4: mid-frame SOP restart, then abort
    do_reset();
    mm_wr(REG_CONTROL, 32'h1);
    for (int i = 0; i < 5; i++) beat(24'h40 + 24'(i), i == 0, 1'b0, 1'b1, i);
    beat(24'h50, 1'b1, 1'b0, 1'b1, 0);
    for (int j = 1; j < 4; j++) beat(24'h50 + 24'(j), 1'b0, 1'b0, 1'b1, j);
    gap(1);
    mm_rd_chk("t4_capture", REG_STATUS, 32'hA);
    mm_wr(REG_CONTROL, 32'h8);
    mm_rd_chk("t4_abort_status", REG_STATUS, 32'h8);
    mm_rd_chk("t4_frame_count", REG_FRAME_COUNT, 32'd0);
    beat(24'h60, 1'b1, 1'b0, 1'b0, 0);
    gap(2);
    chk("t4_q_empty", 32'(exp_q.size()), 32'd0);

    // 5: arm+abort together, then reset mid-capture
    do_reset();
    mm_wr(REG_CONTROL, 32'h9);
    mm_rd_chk("t5_arm_abort", REG_STATUS, 32'h0);
    beat(24'h70, 1'b1, 1'b0, 1'b0, 0);
    gap(2);
    mm_wr(REG_CONTROL, 32'h7);
    frame(32'h800, 16, 15, 16);
    mm_rd_chk("t5_frame_count", REG_FRAME_COUNT, 32'd1);
    chk("t5_irq_pre", {31'b0, frame_irq}, 32'd1);
    for (int i = 0; i < 3; i++) beat(24'h900 + 24'(i), i == 0, 1'b0, 1'b1, i);
    beat(24'h9FF, 1'b0, 1'b0, 1'b0, 0);
    chk("t5_wr_en_pre", {31'b0, buf_wr_en}, 32'd1);
    reset = 1'b1;
    #1;
    chk("t5_rst_wr_en", {31'b0, buf_wr_en}, 32'd0);
    chk("t5_rst_addr", 32'(buf_wr_addr), 32'd0);
    chk("t5_rst_data", buf_wr_data, 32'd0);
    chk("t5_rst_readdata", mm_readdata, 32'd0);
    chk("t5_rst_irq", {31'b0, frame_irq}, 32'd0);
    sink_valid = 1'b0;
    tick();
    reset = 1'b0;
    tick();
    mm_rd_chk("t5_status", REG_STATUS, 32'h0);
    mm_rd_chk("t5_fc_cleared", REG_FRAME_COUNT, 32'd0);
    chk("t5_q_empty", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
